sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one 1RW 64+1-bit SRAM macro (byte write mask, spare bit) between NUM_REQ requesters.
//  Round-robin valid/ready arbitration; one access per cycle.
//  Optional zero-fill init after reset.
//  Captures macro read data and returns it, tagged per requester.
//  Sits between the core's memory clients and the SRAM macro instance.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2)
//  ADDR_W      11  word address width; depth = 1<<ADDR_W
//  DATA_W      65  data width: bits [63:0] byte-masked, bit [64] spare
//  NUM_WMASKS  8   byte-enable count, covers bits [63:0]
//  INIT_ZERO   1   1: write zeros to every word after reset before serving requests
// PORTS
//  clk              in   1                 clock; SRAM clk0 is driven from the same net
//  rst_n            in   1                 async reset, active-low
//  req_valid        in   NUM_REQ           request valid, one bit per requester
//  req_ready        out  NUM_REQ           request accepted this cycle (one-hot or 0)
//  req_we           in   NUM_REQ           1=write 0=read
//  req_addr         in   NUM_REQ*ADDR_W    packed word addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata        in   NUM_REQ*DATA_W    packed write data
//  req_wmask        in   NUM_REQ*NUM_WMASKS packed byte enables
//  req_spare_wen    in   NUM_REQ           spare-bit write enable
//  rsp_valid        out  NUM_REQ           read data valid for requester i (one-hot or 0)
//  rsp_rdata        out  DATA_W            read data, shared bus
//  init_done        out  1                 1 once init finishes (or immediately if INIT_ZERO=0)
//  sram_csb0        out  1                 macro chip select, active-low
//  sram_web0        out  1                 macro write enable, active-low
//  sram_wmask0      out  NUM_WMASKS        macro byte mask
//  sram_spare_wen0  out  1                 macro spare-bit write enable
//  sram_addr0       out  ADDR_W            macro address
//  sram_din0        out  DATA_W            macro write data
//  sram_dout0       in   DATA_W            macro read data
// BEHAVIOUR
//  Reset values:
//  - req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0 (1 if INIT_ZERO=0).
//  - sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_spare_wen0=0, sram_addr0=0, sram_din0=0.
//  - RR pointer=0; init counter=0.
//  FSM states:
//  - INIT: one write per cycle, addr = counter, din=0, wmask=all 1s, spare_wen=1.
//    counter++ each cycle; after addr (1<<ADDR_W)-1 go to RUN. init_done=1 from the first RUN cycle.
//    req_ready=0 throughout INIT.
//  - RUN: serve requests. Entered straight from reset when INIT_ZERO=0.
//  Arbitration (RUN):
//  - grant = first i with req_valid[i], scanning from ptr, ptr+1, ... mod NUM_REQ.
//  - req_ready[grant]=1 in the same cycle, combinational from req_valid.
//  - On a grant, ptr <= grant+1 mod NUM_REQ. With no valid request, ptr holds.
//  - A requester holds valid and payload stable until ready. Valid-to-ready is combinational; there is no backpressure path.
//  SRAM drive:
//  - Macro pins are combinational from the granted request in grant cycle N; the macro samples them at the end of N.
//  - No grant: csb0=1; other macro pins don't-care, driven 0.
//  - Write: web0=0; wmask, spare_wen, din passed through.
//  - Read: web0=1; wmask0=0; spare_wen0=0.
//  Read latency:
//  - sram_dout0 is valid only late in cycle N+1 (X outside that window).
//  - rdata_q captures it at the end of N+1.
//  - rsp_valid[i]=1 and rsp_rdata=rdata_q in cycle N+2, for exactly one cycle.
//  - A 2-stage requester-tag pipe tracks the read; one read may issue every cycle (fully pipelined).
//  - rsp_rdata holds its last value when rsp_valid=0.
//  - Writes produce no response.
//  Hazards: a read granted in N+1 after a write to the same address in N returns the new data (the macro commits the write at mid N+1).
//  Reset mid-operation:
//  - Outputs go to reset values immediately (async); in-flight read tags are dropped and no rsp_valid follows.
//  - The FSM restarts INIT if INIT_ZERO=1.
//  - An access sampled by the macro on the edge of reset assertion may still complete; not guaranteed.
// STRUCTURE
//  Package sram_ctrl_pkg:
//  - state enum {ST_INIT, ST_RUN}
//  - default width constants (ADDR_W, DATA_W, NUM_WMASKS)
//  - typedef sram_req_t {we, addr, wdata, wmask, spare_wen}
//  Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs one-hot gnt[N], gnt_idx.
//  Top level holds the FSM, init counter, tag pipe, rdata_q and the macro muxing.
// TESTING (bench instantiates the real macro model)
//  1. INIT_ZERO=1, ADDR_W=4: release reset -> 16 writes at addr 0..15, init_done high in cycle 17; then reads of 0..15 return 0.
//  2. Req0 writes 0x0123456789ABCDEF (wmask=0xFF, spare=1) to addr 5; next cycle it reads addr 5 -> rsp_valid[0] 2 cycles after the read grant, rdata={1,0x0123456789ABCDEF}.
//  3. Partial write: wmask=0x0F, wdata=all 1s over a zero word -> readback 0x00000000FFFFFFFF, spare bit 0.
//  4. Both requesters hold valid for 6 cycles -> grants alternate 0,1,0,1,0,1; each rsp_valid is one-hot and lands in its own issue cycle+2.
//  5. Back-to-back reads of addr 1,2,3 by req1 -> rsp_valid[1] high 3 consecutive cycles with the matching data, no bubbles.
//  6. Assert rst_n while a read is in flight -> rsp_valid stays 0, sram_csb0=1 immediately, INIT restarts.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the SRAM port arbiter.
// The default geometry matches the 2K x (64+1) macro.
package sram_ctrl_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int SRAM_ADDR_W     = 11;
    localparam int SRAM_DATA_W     = 65;
    localparam int SRAM_NUM_WMASKS = 8;

    // Request payload for the default macro geometry.
    typedef struct packed {
        logic                       we;
        logic [SRAM_ADDR_W-1:0]     addr;
        logic [SRAM_DATA_W-1:0]     wdata;
        logic [SRAM_NUM_WMASKS-1:0] wmask;
        logic                       spare_wen;
    } sram_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand     = (int'(ptr) + k) % N;
            cand_idx = IDX_W'(cand);
            if (!gnt_valid && req[cand_idx]) begin
                gnt_valid     = 1'b1;
                gnt_idx       = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1RW SRAM macro between NUM_REQ requesters with round-robin grants,
// optional zero-fill after reset and a two-stage read-tag pipe.
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
    parameter int INIT_ZERO  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*NUM_WMASKS-1:0] req_wmask,
    input  logic [NUM_REQ-1:0]            req_spare_wen,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          init_done,
    output logic                          sram_csb0,
    output logic                          sram_web0,
    output logic [NUM_WMASKS-1:0]         sram_wmask0,
    output logic                          sram_spare_wen0,
    output logic [ADDR_W-1:0]             sram_addr0,
    output logic [DATA_W-1:0]             sram_din0,
    input  logic [DATA_W-1:0]             sram_dout0
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam state_t RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W-1:0]     wdata;
        logic [NUM_WMASKS-1:0] wmask;
        logic                  spare_wen;
    } req_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  init_cnt_q, init_cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               tag1_valid_q, tag1_valid_d;
    logic [IDX_W-1:0]   tag1_idx_q, tag1_idx_d;
    logic               tag2_valid_q, tag2_valid_d;
    logic [IDX_W-1:0]   tag2_idx_q, tag2_idx_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    req_t               reqs [NUM_REQ];
    req_t               sel;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign reqs[gi] = '{
                we:        req_we[gi],
                addr:      req_addr[gi*ADDR_W +: ADDR_W],
                wdata:     req_wdata[gi*DATA_W +: DATA_W],
                wmask:     req_wmask[gi*NUM_WMASKS +: NUM_WMASKS],
                spare_wen: req_spare_wen[gi]
            };
            assign rsp_valid[gi] = tag2_valid_q && (tag2_idx_q == IDX_W'(gi));
        end
    endgenerate

    // rst_n gates the combinational paths so the macro is deselected the moment reset asserts.
    assign arb_req = (rst_n && state_q == ST_RUN) ? req_valid : '0;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (arb_req),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign sel       = reqs[gnt_idx];
    assign req_ready = gnt;
    assign rsp_rdata = rdata_q;
    assign init_done = (state_q == ST_RUN);

    always_comb begin
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        ptr_d           = ptr_q;
        sram_csb0       = 1'b1;
        sram_web0       = 1'b1;
        sram_wmask0     = '0;
        sram_spare_wen0 = 1'b0;
        sram_addr0      = '0;
        sram_din0       = '0;
        if (rst_n) begin
            case (state_q)
                ST_INIT: begin
                    sram_csb0       = 1'b0;
                    sram_web0       = 1'b0;
                    sram_wmask0     = '1;
                    sram_spare_wen0 = 1'b1;
                    sram_addr0      = init_cnt_q;
                    init_cnt_d      = init_cnt_q + 1'b1;
                    if (&init_cnt_q) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (gnt_valid) begin
                        sram_csb0  = 1'b0;
                        sram_addr0 = sel.addr;
                        ptr_d      = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                        if (sel.we) begin
                            sram_web0       = 1'b0;
                            sram_wmask0     = sel.wmask;
                            sram_spare_wen0 = sel.spare_wen;
                            sram_din0       = sel.wdata;
                        end
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

    // Read tag follows the access: grant -> macro data cycle -> response cycle.
    always_comb begin
        tag1_valid_d = gnt_valid && !sel.we;
        tag1_idx_d   = gnt_idx;
        tag2_valid_d = tag1_valid_q;
        tag2_idx_d   = tag1_idx_q;
        rdata_d      = tag1_valid_q ? sram_dout0 : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            init_cnt_q   <= '0;
            ptr_q        <= '0;
            tag1_valid_q <= 1'b0;
            tag1_idx_q   <= '0;
            tag2_valid_q <= 1'b0;
            tag2_idx_q   <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            ptr_q        <= ptr_d;
            tag1_valid_q <= tag1_valid_d;
            tag1_idx_q   <= tag1_idx_d;
            tag2_valid_q <= tag2_valid_d;
            tag2_idx_q   <= tag2_idx_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural 1RW macro model
// (write commits mid next cycle, read data appears mid next cycle).
module tb_sram_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 4;
    localparam int DW = 65;
    localparam int NW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*NW-1:0]  req_wmask;
    logic [NR-1:0]     req_spare_wen;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              init_done;
    logic              sram_csb0;
    logic              sram_web0;
    logic [NW-1:0]     sram_wmask0;
    logic              sram_spare_wen0;
    logic [AW-1:0]     sram_addr0;
    logic [DW-1:0]     sram_din0;
    logic [DW-1:0]     sram_dout0;

    sram_port_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_WMASKS(NW), .INIT_ZERO(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .req_spare_wen(req_spare_wen),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_spare_wen0(sram_spare_wen0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk = ~clk;

    // ---------------- macro model ----------------
    logic [DW-1:0] mem [1<<AW];
    logic          m_csb = 1'b1;
    logic          m_web = 1'b1;
    logic          m_spare = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;
    logic [NW-1:0] m_mask = '0;

    always @(posedge clk) begin
        m_csb      <= sram_csb0;
        m_web      <= sram_web0;
        m_spare    <= sram_spare_wen0;
        m_addr     <= sram_addr0;
        m_din      <= sram_din0;
        m_mask     <= sram_wmask0;
        sram_dout0 <= 'x;
    end

    always @(negedge clk) begin
        if (!m_csb) begin
            if (!m_web) begin
                for (int b = 0; b < NW; b++)
                    if (m_mask[b]) mem[m_addr][b*8 +: 8] = m_din[b*8 +: 8];
                if (m_spare) mem[m_addr][64] = m_din[64];
            end else begin
                sram_dout0 <= mem[m_addr];
            end
        end
    end

    // ---------------- bookkeeping ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NW-1:0] wmask;
        logic          spare;
        logic [DW-1:0] exp;
    } cmd_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    cmd_t cmdq [NR][$];
    sb_t  sb [$];
    int   gnt_log [$];
    int   rsp_log [$];
    int   cyc = 0;
    int   nchecks = 0;
    int   nerrors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [NW-1:0] m, input logic s);
        cmd_t c;
        c.we = 1'b1; c.addr = a; c.wdata = d; c.wmask = m; c.spare = s; c.exp = '0;
        cmdq[i].push_back(c);
    endtask

    task automatic push_rd(input int i, input logic [AW-1:0] a, input logic [DW-1:0] e);
        cmd_t c;
        c.we = 1'b0; c.addr = a; c.wdata = '0; c.wmask = '0; c.spare = 1'b0; c.exp = e;
        cmdq[i].push_back(c);
    endtask

    // Driver: present the head of each requester queue until it is granted.
    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        req_wmask = '0; req_spare_wen = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (rst_n && cmdq[i].size() > 0) begin
                    req_valid[i]           = 1'b1;
                    req_we[i]              = cmdq[i][0].we;
                    req_addr[i*AW +: AW]   = cmdq[i][0].addr;
                    req_wdata[i*DW +: DW]  = cmdq[i][0].wdata;
                    req_wmask[i*NW +: NW]  = cmdq[i][0].wmask;
                    req_spare_wen[i]       = cmdq[i][0].spare;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Grant observer: retire granted commands, schedule expected read responses.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            check("ready_onehot", {64'd0, $onehot(req_ready)}, 65'd1);
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    if (!req_valid[i] || cmdq[i].size() == 0) begin
                        check("ready_without_valid", {64'd0, req_valid[i]}, 65'd1);
                    end else begin
                        cmd_t c;
                        sb_t  e;
                        c = cmdq[i].pop_front();
                        gnt_log.push_back(i);
                        $display("grant req%0d %s addr=%0d cycle=%0d", i, c.we ? "WR" : "RD", c.addr, cyc);
                        if (!c.we) begin
                            e.idx = i; e.data = c.exp; e.due = cyc + 2;
                            sb.push_back(e);
                        end
                    end
                end
            end
        end
    end

    // Monitor: compare each response against the scoreboard head.
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", {63'd0, rsp_valid}, 65'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                rsp_log.push_back(cyc);
                $display("rsp req%0d data=%h cycle=%0d", e.idx, rsp_rdata, cyc);
                check("rsp_valid_onehot", {63'd0, rsp_valid}, {63'd0, 2'(1 << e.idx)});
                check("rsp_rdata", rsp_rdata, e.data);
                check("rsp_latency", 65'(cyc), 65'(e.due));
            end
        end
    end

    task automatic wait_idle();
        logic busy;
        busy = 1'b1;
        for (int k = 0; k < 300 && busy; k++) begin
            @(negedge clk);
            busy = (cmdq[0].size() != 0) || (cmdq[1].size() != 0) || (sb.size() != 0);
        end
        check("idle_timeout", {64'd0, busy}, 65'd0);
    endtask

    localparam logic [DW-1:0] D5 = {1'b1, 64'h0123456789ABCDEF};
    localparam logic [DW-1:0] D1 = {1'b1, 64'h1111_0000_AAAA_5555};
    localparam logic [DW-1:0] D2 = {1'b0, 64'h2222_1111_BBBB_6666};
    localparam logic [DW-1:0] D3 = {1'b1, 64'h3333_2222_CCCC_7777};
    localparam logic [DW-1:0] D6 = {1'b0, 64'h0000_0000_FFFF_FFFF};

    initial begin
        logic granted;
        rst_n = 1'b0;
        for (int k = 0; k < (1 << AW); k++) mem[k] = {1'b1, 64'hDEAD_BEEF_0000_0000} | 65'(k);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 65'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 65'd0);
        check("rst_rsp_rdata", rsp_rdata, 65'd0);
        check("rst_init_done", {64'd0, init_done}, 65'd0);
        check("rst_csb_web", {63'd0, sram_csb0, sram_web0}, 65'd3);
        check("rst_mask_spare", {56'd0, sram_wmask0, sram_spare_wen0}, 65'd0);
        check("rst_addr", {61'd0, sram_addr0}, 65'd0);
        check("rst_din", sram_din0, 65'd0);

        // Test 1: zero-fill sequence, then readback
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < (1 << AW); k++) begin
            @(negedge clk);
            check("init_write", {sram_csb0, sram_web0, sram_addr0, sram_wmask0, sram_spare_wen0, init_done},
                  {2'b00, 4'(k), 8'hFF, 1'b1, 1'b0});
            check("init_din", sram_din0, 65'd0);
        end
        @(negedge clk);
        check("init_done_cycle17", {64'd0, init_done}, 65'd1);
        check("idle_csb", {64'd0, sram_csb0}, 65'd1);
        for (int a = 0; a < (1 << AW); a++) push_rd(0, 4'(a), 65'd0);
        wait_idle();

        // Test 2: full write then read-after-write hazard
        push_wr(0, 4'd5, D5, 8'hFF, 1'b1);
        push_rd(0, 4'd5, D5);
        wait_idle();

        // Test 3: partial byte-masked write over a zero word
        push_wr(0, 4'd6, '1, 8'h0F, 1'b0);
        push_rd(0, 4'd6, D6);
        wait_idle();

        // Test 5: back-to-back reads by req1
        push_wr(1, 4'd1, D1, 8'hFF, 1'b1);
        push_wr(1, 4'd2, D2, 8'hFF, 1'b1);
        push_wr(1, 4'd3, D3, 8'hFF, 1'b1);
        wait_idle();
        rsp_log.delete();
        push_rd(1, 4'd1, D1);
        push_rd(1, 4'd2, D2);
        push_rd(1, 4'd3, D3);
        wait_idle();
        check("b2b_count", 65'(rsp_log.size()), 65'd3);
        if (rsp_log.size() == 3) begin
            check("b2b_gap1", 65'(rsp_log[1] - rsp_log[0]), 65'd1);
            check("b2b_gap2", 65'(rsp_log[2] - rsp_log[1]), 65'd1);
        end

        // Test 4: both requesters contend; grants must alternate starting from req0
        gnt_log.delete();
        push_rd(0, 4'd5, D5);
        push_rd(1, 4'd2, D2);
        push_rd(0, 4'd6, D6);
        push_rd(1, 4'd3, D3);
        push_rd(0, 4'd1, D1);
        push_rd(1, 4'd5, D5);
        wait_idle();
        check("rr_count", 65'(gnt_log.size()), 65'd6);
        for (int k = 0; k < gnt_log.size() && k < 6; k++)
            check("rr_order", 65'(gnt_log[k]), 65'(k % 2));

        // Test 6: reset while a read is in flight
        push_rd(0, 4'd5, D5);
        granted = 1'b0;
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            granted = (sb.size() != 0);
        end
        check("inflight_grant", {64'd0, granted}, 65'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_csb", {64'd0, sram_csb0}, 65'd1);
        check("midrst_rsp_valid", {63'd0, rsp_valid}, 65'd0);
        check("midrst_init_done", {64'd0, init_done}, 65'd0);
        check("midrst_ready", {63'd0, req_ready}, 65'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reinit_first", {sram_csb0, sram_web0, sram_addr0, init_done}, {2'b00, 4'd0, 1'b0});
        repeat (18) @(negedge clk);
        check("reinit_done", {64'd0, init_done}, 65'd1);
        push_rd(1, 4'd5, 65'd0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
